// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store sequencer to a variable-latency data memory, with read-modify-write for sub-doubleword stores.
// Latency: load/sd done 2 cycles after start, sw/sh/sb done 4 cycles after start, error done 1 cycle after start; each cycle without mem_ready adds 1.
// Backpressure: start is sampled only in IDLE and is otherwise dropped; mem_ready stalls the request, and a timeout aborts it.
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  InstrIType,
  input  logic [63:0] addr,
  input  logic [63:0] extendToMem,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  output logic [63:0] outMDR,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_type;
  logic            r_err;
  logic [CW-1:0]   r_cnt;
  logic [63:0]     r_addr;
  logic [63:0]     r_wdata;
  logic [63:0]     r_mdr;

  logic [2:0]      w_size_mask;
  logic            w_invalid;
  logic            w_bad;
  logic            w_in_sd;
  logic            w_rmw;
  logic            w_req;
  logic            w_timeout;
  logic            w_accept;

  // Decode the live command: alignment mask per access size, invalid codes flagged
  always_comb begin
    w_size_mask = 3'b000;
    w_invalid   = 1'b0;
    case (InstrIType)
      4'd0, 4'd3, 4'd9: w_size_mask = 3'b000;
      4'd1, 4'd4, 4'd8: w_size_mask = 3'b001;
      4'd2, 4'd5, 4'd7: w_size_mask = 3'b011;
      4'd6, 4'd10:      w_size_mask = 3'b111;
      default:          w_invalid   = 1'b1;
    endcase
  end

  assign w_bad     = w_invalid | (|(addr[2:0] & w_size_mask));
  assign w_in_sd   = (InstrIType == 4'd6);
  assign w_rmw     = (r_type == 4'd7) || (r_type == 4'd8) || (r_type == 4'd9);
  assign w_req     = (r_state == S_RD) || (r_state == S_WR);
  assign w_timeout = w_req && !mem_ready && (r_cnt == CW'(TIMEOUT - 1));
  assign w_accept  = (r_state == S_IDLE) && start;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a timed-out request falls through to DONE with no completion
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad)        w_next = S_DONE;
          else if (w_in_sd) w_next = S_WR;
          else              w_next = S_RD;
        end
      end
      S_RD: begin
        if (mem_ready)      w_next = w_rmw ? S_MERGE : S_DONE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_MERGE: w_next = S_WR;
      S_WR: begin
        if (mem_ready || w_timeout) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Command capture: address and type on accept, error flag on bad command or timeout
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr <= '0;
      r_type <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= addr;
        r_type <= InstrIType;
      end
      if (r_state == S_IDLE) r_err <= w_accept & w_bad;
      else if (w_timeout)    r_err <= 1'b1;
    end
  end

  // Wait counter: cleared on entering a request state, counts cycles without ready
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if ((w_next == S_RD || w_next == S_WR) && (w_next != r_state)) begin
      r_cnt <= '0;
    end else if (w_req && !mem_ready) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Data path: write data from sd at accept or merged word in MERGE; MDR only on completed read
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wdata <= '0;
      r_mdr   <= '0;
    end else begin
      if (w_accept && w_in_sd && !w_bad) r_wdata <= extendToMem;
      else if (r_state == S_MERGE)       r_wdata <= extendToMem;
      if (r_state == S_RD && mem_ready)  r_mdr   <= mem_rdata;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign outMDR    = r_mdr;
  assign mem_rd    = (r_state == S_RD);
  assign mem_wr    = (r_state == S_WR);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = (r_state == S_DONE) && r_err;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multicycle data-memory sequencer between the control unit and the load/store extend stage. Accepts one load/store command at a time and drives the variable-latency data memory. For loads it latches the returned doubleword into the MDR register feeding the extend stage. For sub-doubleword stores it performs read-modify-write, writing back the merged word the extend stage produces.

## Interface
- TIMEOUT, 16: max cycles to wait for mem_ready before aborting; counter width $clog2(TIMEOUT+1).
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  command valid; sampled only in IDLE.
- InstrIType  in  4  type code: 0000 lb, 0001 lh, 0010 lw, 0011 lbu, 0100 lhu, 0101 lwu, 0110 sd, 0111 sw, 1000 sh, 1001 sb, 1010 ld; 1011–1111 invalid.
- addr  in  64  byte address.
- extendToMem  in  64  merged store data from the extend stage.
- mem_rdata  in  64  memory read data.
- mem_ready  in  1  memory completes the current read or write this cycle.
- mem_addr  out  64  registered address.
- mem_rd  out  1  read request level.
- mem_wr  out  1  write request level.
- mem_wdata  out  64  registered write data.
- outMDR  out  64  MDR register. Feeds the extend stage's load input and, during stores, its DataMemOut input.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, coincident with done, on misalign, invalid type or timeout.

## Operation
- States: IDLE, RD, MERGE, WR, DONE.
- IDLE + start: latch addr into mem_addr, then check the command.
  - Invalid type, or misaligned address: go to DONE with err, no memory access.
  - Misaligned means addr[0]≠0 for lh/lhu/sh, addr[1:0]≠0 for lw/lwu/sw, addr[2:0]≠0 for ld/sd. Byte ops never misalign.
  - Loads and sw/sh/sb: go to RD.
  - sd: latch extendToMem into mem_wdata and go to WR.
- RD: mem_rd=1. On mem_ready, outMDR ← mem_rdata. Loads then go to DONE; sw/sh/sb go to MERGE.
- MERGE: one cycle with no memory request, so the extend stage settles on the new outMDR. Latch extendToMem into mem_wdata, then go to WR.
- WR: mem_wr=1. On mem_ready, go to DONE.
- DONE: done=1, plus err if flagged. Next state is IDLE.
- Timeout: a counter clears on entry to RD or WR and increments each cycle mem_ready=0. At count TIMEOUT−1 with no ready, go to DONE with err, deassert the request, leave outMDR unchanged and write nothing.
- mem_rd and mem_wr are never both high. Both are low outside RD and WR.
- outMDR changes only on a completed read.
- start outside IDLE is ignored, with no queueing.

## Timing
- Reset (async, reset=0): state IDLE; mem_addr, mem_wdata, outMDR = 0; mem_rd, mem_wr, busy, done, err = 0; timeout counter = 0.
- Reset asserted mid-operation aborts immediately: request lines drop asynchronously and no write completes.
- Request levels hold until the mem_ready cycle. mem_addr and mem_wdata are stable for the whole request.
- Cycle latencies, start edge = edge 0, with mem_ready in the first request cycle:
  - Load: RD in cycle 1, done in cycle 2.
  - sd: WR in cycle 1, done in cycle 2.
  - sw/sh/sb: RD 1, MERGE 2, WR 3, done in cycle 4.
  - Error from IDLE: done and err in cycle 1.
- Each wait cycle without mem_ready adds one cycle.
- start in the DONE cycle is ignored. The next command is accepted at the earliest in the cycle after done.

## Test plan
- Load: lw at addr 0x100, mem_rdata=0x0000_0000_8000_0001, ready after 2 wait cycles. Expect mem_rd high for exactly 3 cycles, outMDR=0x0000_0000_8000_0001, done in cycle 4, err=0.
- Sub-word store: sb at 0x203, readback 0x1122_3344_5566_7788, extend stage returns 0x1122_3344_5566_77AB in MERGE. Expect mem_wdata=0x1122_3344_5566_77AB, one mem_wr cycle, done in cycle 4, mem_rd and mem_wr never overlapping.
- Full store: sd at 0x40, extendToMem=0xDEAD_BEEF_CAFE_F00D at start, immediate ready. Expect no mem_rd, mem_wr in cycle 1, done in cycle 2.
- Errors:
  - lh at 0x101: done and err in cycle 1, no request.
  - InstrIType=1100: same response.
  - ld at 0x108 with mem_ready held low: err and done after TIMEOUT wait cycles, outMDR unchanged.
- Back-to-back and start filtering:
  - start held high across two lw commands: second accepted only in the cycle after done.
  - start pulses while busy: ignored.
- Mid-operation reset: reset=0 during WR wait. Expect mem_wr=0 immediately and all outputs at reset values. After release, a new ld completes normally.
